// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: state encoding, per-entry flag record and flag derivation.
// Optional ALU_RESULT_PARITY_EN adds a parity bit to the flag record.
package alu_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned FLAG_WORD_W = 64;

  typedef enum logic [STATE_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic neg;
`ifdef ALU_RESULT_PARITY_EN
    logic parity;
`endif
  } flags_t;

  // Word is zero-extended by the caller, so zero/parity see only the live bits.
  function automatic flags_t calc_flags(input logic [FLAG_WORD_W-1:0] word,
                                        input int unsigned            width);
    flags_t f;
    f      = '0;
    f.zero = (word == '0);
    f.neg  = word[6'(width - 1)];
`ifdef ALU_RESULT_PARITY_EN
    f.parity = ^word;
`endif
    return f;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Result handshake bundle between the mux bank, the result stage and its consumer.
// Optional ALU_RESULT_PARITY_EN adds out_parity.
interface alu_result_stage_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;
`ifdef ALU_RESULT_PARITY_EN
  logic             out_parity;
`endif

  // Environment side: produces results upstream and consumes them downstream.
  modport master (
    output in_valid, in_data, in_carry, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_neg, out_carry
`ifdef ALU_RESULT_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  in_valid, in_data, in_carry, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_neg, out_carry
`ifdef ALU_RESULT_PARITY_EN
    , output out_parity
`endif
  );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational status-flag derivation for a result word (zero, negative, optional parity).
// Optional ALU_RESULT_PARITY_EN adds parity_c.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             zero_c,
  output logic             neg_c
`ifdef ALU_RESULT_PARITY_EN
  ,
  output logic             parity_c
`endif
);

  flags_t flags_c;

  assign flags_c = calc_flags(FLAG_WORD_W'(data), WIDTH);
  assign zero_c  = flags_c.zero;
  assign neg_c   = flags_c.neg;
`ifdef ALU_RESULT_PARITY_EN
  assign parity_c = flags_c.parity;
`endif

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry skid buffer with capture-time flags and a saturating delivery counter.
// Optional ALU_RESULT_PARITY_EN adds out_parity stored per entry.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_result_stage_if.slave  bus,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   result_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
    flags_t           flags;
  } entry_t;

  state_e             state_q, state_d;
  entry_t             main_q, main_d;
  entry_t             skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept_c;
  logic               deliver_c;
  entry_t             in_entry_c;
  logic               in_zero_c;
  logic               in_neg_c;
`ifdef ALU_RESULT_PARITY_EN
  logic               in_parity_c;
`endif

  // Flags are resolved on the input side so the output path is a bare register.
  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .data     (bus.in_data),
    .zero_c   (in_zero_c),
    .neg_c    (in_neg_c)
`ifdef ALU_RESULT_PARITY_EN
    ,
    .parity_c (in_parity_c)
`endif
  );

  always_comb begin
    in_entry_c            = '0;
    in_entry_c.data       = bus.in_data;
    in_entry_c.carry      = bus.in_carry;
    in_entry_c.flags.zero = in_zero_c;
    in_entry_c.flags.neg  = in_neg_c;
`ifdef ALU_RESULT_PARITY_EN
    in_entry_c.flags.parity = in_parity_c;
`endif
  end

  assign accept_c  = bus.in_valid && in_ready_q;
  assign deliver_c = out_valid_q && bus.out_ready;

  // Next-state, storage steering and registered handshake outputs.
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          main_d  = in_entry_c;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept_c && !deliver_c) begin
          skid_d  = in_entry_c;
          state_d = ST_FULL;
        end else if (accept_c && deliver_c) begin
          main_d  = in_entry_c;
        end else if (deliver_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deliver_c) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // Clear wins over a same-cycle delivery; count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (deliver_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q.data;
  assign bus.out_carry = main_q.carry;
  assign bus.out_zero  = main_q.flags.zero;
  assign bus.out_neg   = main_q.flags.neg;
`ifdef ALU_RESULT_PARITY_EN
  assign bus.out_parity = main_q.flags.parity;
`endif
  assign result_cnt    = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model plus directed literal checks.
// Exercises the ALU_RESULT_PARITY_EN path when that macro is defined.
module tb_alu_result_stage;

  localparam int unsigned W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_clr;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  alu_result_stage_if #(.WIDTH(W)) ifa ();
  alu_result_stage_if #(.WIDTH(W)) ifb ();

  alu_result_stage #(.WIDTH(W), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifa),
    .cnt_clr    (cnt_clr),
    .result_cnt (cnt16)
  );

  alu_result_stage #(.WIDTH(W), .CNT_W(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifb),
    .cnt_clr    (cnt_clr),
    .result_cnt (cnt4)
  );

  // The narrow-counter instance sees identical traffic.
  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_data   = ifa.in_data;
  assign ifb.in_carry  = ifa.in_carry;
  assign ifb.out_ready = ifa.out_ready;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two {carry,data} results.
  logic [W:0] q[$];
  int mcnt  = 0;
  int mcnt4 = 0;

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    bit del;
    if (!rst_n) begin
      q.delete();
      mcnt  = 0;
      mcnt4 = 0;
    end else begin
      acc = ifa.in_valid && (q.size() < 2);
      del = (q.size() > 0) && ifa.out_ready;
      if (cnt_clr) begin
        mcnt  = 0;
        mcnt4 = 0;
      end else if (del) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt4 < 15) mcnt4++;
      end
      if (del) void'(q.pop_front());
      if (acc) q.push_back({ifa.in_carry, ifa.in_data});
    end
  end

  always @(negedge clk) begin
    logic [W:0] e;
    chk("in_ready",   32'(ifa.in_ready),  32'(q.size() < 2));
    chk("out_valid",  32'(ifa.out_valid), 32'(q.size() > 0));
    chk("in_ready4",  32'(ifb.in_ready),  32'(q.size() < 2));
    chk("out_valid4", 32'(ifb.out_valid), 32'(q.size() > 0));
    chk("cnt16",      32'(cnt16),         32'(mcnt));
    chk("cnt4",       32'(cnt4),          32'(mcnt4));
    if (q.size() > 0) begin
      e = q[0];
      chk("out_data",  32'(ifa.out_data),  32'(e[W-1:0]));
      chk("out_carry", 32'(ifa.out_carry), 32'(e[W]));
      chk("out_zero",  32'(ifa.out_zero),  32'(e[W-1:0] == '0));
      chk("out_neg",   32'(ifa.out_neg),   32'(e[W-1]));
      chk("out_data4", 32'(ifb.out_data),  32'(e[W-1:0]));
`ifdef ALU_RESULT_PARITY_EN
      chk("out_parity", 32'(ifa.out_parity), 32'(^e[W-1:0]));
`endif
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(ifa.out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(ifa.in_ready),  32'd1);
    chk({tag, "_out_data"},  32'(ifa.out_data),  32'd0);
    chk({tag, "_out_zero"},  32'(ifa.out_zero),  32'd0);
    chk({tag, "_out_neg"},   32'(ifa.out_neg),   32'd0);
    chk({tag, "_out_carry"}, 32'(ifa.out_carry), 32'd0);
    chk({tag, "_cnt16"},     32'(cnt16),         32'd0);
    chk({tag, "_cnt4"},      32'(cnt4),          32'd0);
`ifdef ALU_RESULT_PARITY_EN
    chk({tag, "_out_parity"}, 32'(ifa.out_parity), 32'd0);
`endif
  endtask

  initial begin
    rst_n         = 1'b1;
    cnt_clr       = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.in_data   = '0;
    ifa.in_carry  = 1'b0;
    ifa.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single pass of a zero result with carry.
    ifa.in_valid = 1'b1; ifa.in_data = 8'h00; ifa.in_carry = 1'b1; ifa.out_ready = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0; ifa.in_carry = 1'b0;
    chk("sp_valid", 32'(ifa.out_valid), 32'd1);
    chk("sp_zero",  32'(ifa.out_zero),  32'd1);
    chk("sp_neg",   32'(ifa.out_neg),   32'd0);
    chk("sp_carry", 32'(ifa.out_carry), 32'd1);
    @(negedge clk);
    chk("sp_cnt",   32'(cnt16),         32'd1);
    chk("sp_empty", 32'(ifa.out_valid), 32'd0);

    // Back-pressure: two results pile up behind a stalled consumer.
    ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.in_data = 8'h80;
    @(negedge clk);
    ifa.in_data = 8'h05;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    chk("bp_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("bp_data",     32'(ifa.out_data), 32'h80);
    chk("bp_neg",      32'(ifa.out_neg),  32'd1);
    @(negedge clk);
    chk("bp_hold",     32'(ifa.out_data), 32'h80);
    ifa.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second",   32'(ifa.out_data), 32'h05);
    chk("bp_neg2",     32'(ifa.out_neg),  32'd0);
    @(negedge clk);
    chk("bp_drained",  32'(ifa.out_valid), 32'd0);
    chk("bp_cnt",      32'(cnt16),         32'd3);

    // Streaming 100 results with a freshly cleared counter.
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_cnt", 32'(cnt16), 32'd0);
    for (int i = 0; i < 100; i++) begin
      ifa.in_valid = 1'b1; ifa.in_data = 8'(i); ifa.in_carry = 1'(i);
      @(negedge clk);
      chk("st_in_ready", 32'(ifa.in_ready), 32'd1);
      chk("st_data",     32'(ifa.out_data), 32'(i));
    end
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("st_cnt",  32'(cnt16), 32'd100);
    chk("st_sat4", 32'(cnt4),  32'd15);

    // Clear and deliver in the same cycle: clear wins.
    ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.in_data = 8'h11;
    @(negedge clk);
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cd_cnt16", 32'(cnt16), 32'd0);
    chk("cd_cnt4",  32'(cnt4),  32'd0);
    chk("cd_empty", 32'(ifa.out_valid), 32'd0);

`ifdef ALU_RESULT_PARITY_EN
    ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.in_data = 8'h07;
    @(negedge clk);
    chk("par_07", 32'(ifa.out_parity), 32'd1);
    ifa.out_ready = 1'b1; ifa.in_data = 8'h03;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    chk("par_03_data", 32'(ifa.out_data),   32'h03);
    chk("par_03",      32'(ifa.out_parity), 32'd0);
    @(negedge clk);
`endif

    // Reset while FULL, with a non-zero counter.
    ifa.out_ready = 1'b1; ifa.in_valid = 1'b1; ifa.in_data = 8'h5A;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    @(negedge clk);
    ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.in_data = 8'hA5;
    @(negedge clk);
    ifa.in_data = 8'h3C;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    chk("pre_rst_full", 32'(ifa.in_ready), 32'd0);
    chk("pre_rst_cnt",  32'(cnt16 != 16'd0), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_full");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(ifa.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage placed directly downstream of the ALU result-select multiplexer bank.
- Captures the selected result word plus carry under a valid/ready handshake.
- Derives status flags at capture time and presents result and flags to the consumer.
- Built as a 2-entry skid buffer so `in_ready` is a pure register output and back-pressure never drops a result.

Parameters:
- WIDTH, 8, result data width in bits (≥1).
- CNT_W, 16, width of the saturating delivered-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept; registered.
- in_data  input  WIDTH  selected result word from the mux bank.
- in_carry  input  1  carry/borrow accompanying in_data.
- out_valid  output  1  result available to consumer.
- out_ready  input  1  consumer accepts.
- out_data  output  WIDTH  registered result.
- out_zero  output  1  out_data == 0.
- out_neg  output  1  out_data[WIDTH-1].
- out_carry  output  1  registered carry.
- cnt_clr  input  1  synchronous clear of result_cnt.
- result_cnt  output  CNT_W  number of results delivered (out_valid && out_ready), saturating.

Behaviour:
- Handshake terms:
  - Accept = in_valid && in_ready.
  - Deliver = out_valid && out_ready.
- Async reset (rst_n low), effective immediately:
  - state=EMPTY, in_ready=1, out_valid=0, out_data=0, out_zero=0, out_neg=0, out_carry=0, result_cnt=0, skid contents=0.
  - Reset mid-transfer discards held entries; no partial result survives.
- Storage:
  - Main register drives out_*.
  - Skid register holds one overflow entry.
  - Each entry = {data, carry, zero, neg}.
  - zero and neg are computed from in_data at the accept edge, not on the output path.
- States (2-bit encoded):
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main full, skid empty, out_valid=1, in_ready=1.
  - FULL: both full, out_valid=1, in_ready=0.
- Transitions:
  - EMPTY --accept--> ONE; the entry is loaded into main.
  - ONE, accept && !deliver --> FULL; the entry is loaded into skid.
  - ONE, accept && deliver --> ONE; the entry is loaded into main (simultaneous pass-through).
  - ONE, !accept && deliver --> EMPTY.
  - FULL, deliver --> ONE; skid moves to main. Accept is impossible here because in_ready=0.
  - Otherwise the state holds.
- Latency: an entry accepted at edge N is visible on out_* from edge N (out_valid high in cycle N+1). Minimum 1 cycle, no combinational in→out path.
- in_ready depends only on state; it never depends combinationally on out_ready.
- Stability: while out_valid && !out_ready, out_* are held constant.
- Ordering: strict FIFO; no duplication, no loss.
- Upstream may drop in_valid without an accept; the consumer may drop out_ready freely.
- result_cnt:
  - Increments by 1 on each deliver.
  - Saturates at 2^CNT_W-1.
  - cnt_clr sets it to 0 and has priority over a same-cycle deliver.

Optional Feature:
- Macro: ALU_RESULT_PARITY_EN.
- Defined:
  - Adds output `out_parity` (1 bit) = XOR reduction of out_data.
  - Parity is computed at accept time and stored per entry like zero/neg.
  - Reset value 0.
- Undefined: the port and its storage are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - Typedef for the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2).
  - Typedef for the entry struct {data, carry, zero, neg[, parity]}.
  - Function computing flags from a data word.
- One sub-module, alu_flag_gen:
  - Purely combinational: data → zero, neg, parity.
  - Instantiated once on the input path.

Test Plan:
- Reset: assert rst_n=0 mid-FULL → all out_* 0, out_valid=0, in_ready=1, result_cnt=0 asynchronously.
- Single pass, WIDTH=8: in_data=8'h00, carry=1, out_ready=1.
  - Next cycle out_valid=1, out_zero=1, out_neg=0, out_carry=1.
  - result_cnt=1 after the deliver.
- Back-pressure: out_ready=0, push 8'h80 then 8'h05.
  - State FULL, in_ready=0.
  - out_data holds 8'h80 with out_neg=1.
  - Raise out_ready → 8'h80 then 8'h05 delivered in order.
- Streaming: in_valid=1 and out_ready=1 for 100 cycles with values 0..99.
  - in_ready stays 1; output sequence equals input delayed 1 cycle.
  - result_cnt=100.
- Counter boundary: CNT_W=4, deliver 20 results → result_cnt=15. cnt_clr and deliver in the same cycle → 0.
- ALU_RESULT_PARITY_EN defined: 8'h07 → out_parity=1; 8'h03 → out_parity=0.
